dpram_bit_reader: RTL and testbench
===================================

Name: dpram_bit_reader

Overview:
- Read-side companion to the packet dual-port RAM: walks a byte region of the RAM and serializes it LSB-first into a bit stream with valid/ready handshake.
- Drives the RAM read address and consumes its same-cycle (combinational) read data.
- Sits between the packet buffer and the GFSK/whitening TX bit path.
- One packet per start pulse; a done pulse is emitted when the packet completes.

Parameters:
- DATA_WIDTH, 8, RAM word width; also the number of bits serialized per word.
- ADDRESS_WIDTH, 11, RAM address width; the address space is 2^ADDRESS_WIDTH words.
- LEN_WIDTH, 12, width of num_word; must satisfy LEN_WIDTH >= ADDRESS_WIDTH+1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request; sampled only in IDLE.
- start_addr  input  ADDRESS_WIDTH  first RAM word of the packet.
- num_word  input  LEN_WIDTH  number of words to send; 0 is legal.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at packet end.
- read_address  output  ADDRESS_WIDTH  RAM read address (registered).
- read_data  input  DATA_WIDTH  RAM data for read_address, same cycle.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out is valid.
- bit_ready  input  1  downstream accepts the bit when bit_valid && bit_ready.
- bit_last  output  1  qualifies the final bit of the packet.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; read_address=0; shift register, bit index and word counter cleared. Reset mid-packet aborts immediately with no done pulse.
- All outputs are registered or decoded from registered state only; there are no combinational paths from input ports to outputs.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE, start=1:
  - num_word==0: go to DONE.
  - otherwise: read_address<=start_addr, words_left<=num_word-1, go to LOAD.
- IDLE: start is ignored in every other state, with no queuing.
- LOAD (exactly 1 cycle): shreg<=read_data; read_address<=read_address+1 (mod 2^ADDRESS_WIDTH); bit_idx<=0; go to SHIFT.
- SHIFT:
  - bit_valid=1 and bit_out=shreg[0].
  - bit_last=1 when words_left==0 and bit_idx==DATA_WIDTH-1.
  - Nothing changes without a handshake. bit_out holds stable while bit_valid && !bit_ready.
- SHIFT, handshake with bit_idx<DATA_WIDTH-1: shreg>>=1; bit_idx++.
- SHIFT, handshake with bit_idx==DATA_WIDTH-1 and words_left>0:
  - shreg<=read_data; read_address++ (wrapping); words_left--; bit_idx<=0.
  - There is no bubble between words.
- SHIFT, handshake with bit_idx==DATA_WIDTH-1 and words_left==0: go to DONE. bit_valid is 0 from the next cycle.
- DONE (1 cycle): done=1, busy=1; then go to IDLE. A start in DONE is ignored.
- Latency: start at edge k gives LOAD at k+1 and bit_valid=1 at k+2.
  - With bit_ready held at 1, the packet occupies num_word*DATA_WIDTH consecutive valid cycles.
  - done is asserted the cycle after the last handshake.
- Wrap-around: a packet crossing address 2^ADDRESS_WIDTH-1 continues at 0.
- num_word > 2^ADDRESS_WIDTH rereads words modulo the address space; this is legal and is not flagged.
- The RAM writer must not modify words in [start_addr, start_addr+num_word) while busy. The reader does not check this.

Decomposition:
- Shared package holds the state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3) and the default widths (BTLE_RAM_DATA_WIDTH=8, BTLE_RAM_ADDRESS_WIDTH=11).
- No sub-module: a single FSM plus datapath. The bench instantiates dpram alongside it.

Test Plan:
- Load RAM[0..2]=0xA5,0x3C,0x01; start_addr=0, num_word=3; bit_ready=1 -> bit stream 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,0,0,0,0,0. bit_valid is high for 24 consecutive cycles starting 2 cycles after start, bit_last on the 24th bit, done one cycle later.
- Same packet with bit_ready toggling 1,0,0,1 pseudo-randomly -> identical bit sequence. bit_out is stable during every stalled cycle.
- start_addr=2046, num_word=3 with RAM[2046]=0x11, RAM[2047]=0x22, RAM[0]=0x33 -> read_address sequence 2046,2047,0. Bytes are emitted 0x11, 0x22, 0x33 LSB-first.
- num_word=0 -> bit_valid never asserts; busy high for 1 cycle, done pulses the next cycle.
- Pulse start again 5 cycles into a 2-word packet -> ignored. Output equals a single packet, exactly one done.
- Assert rst low mid-SHIFT for 1 cycle -> bit_valid, busy and read_address go to 0 asynchronously, no done pulse. A new start after release sends a full packet correctly.

Source files
------------

// File: rtl/dpram_bit_reader_pkg.sv
// Shared types and default widths for the packet-RAM bit reader.
// State encoding is fixed so the FSM can be identified in debug dumps.
package dpram_bit_reader_pkg;

  localparam int unsigned BTLE_RAM_DATA_WIDTH    = 8;
  localparam int unsigned BTLE_RAM_ADDRESS_WIDTH = 11;
  localparam int unsigned BTLE_RAM_LEN_WIDTH     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dpram_bit_reader.sv
// Walks a word region of the packet RAM and serializes it LSB-first onto a
// valid/ready bit stream; one packet per start pulse, done pulse at the end.
module dpram_bit_reader
  import dpram_bit_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = BTLE_RAM_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = BTLE_RAM_ADDRESS_WIDTH,
  parameter int unsigned LEN_WIDTH     = BTLE_RAM_LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]     num_word,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     bit_out,
  output logic                     bit_valid,
  input  logic                     bit_ready,
  output logic                     bit_last
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_shreg;
  logic [IDX_W-1:0]         r_bit_idx;
  logic [LEN_WIDTH-1:0]     r_words_left;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_bit_out;

  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0]    w_shreg_nxt;
  logic [IDX_W-1:0]         w_bit_idx_nxt;
  logic [LEN_WIDTH-1:0]     w_words_left_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic                     w_valid_nxt;
  logic                     w_last_nxt;
  logic                     w_bit_out_nxt;

  // Next-state and datapath decode; outputs are computed from next values
  // so every port is a flop.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_shreg_nxt      = r_shreg;
    w_bit_idx_nxt    = r_bit_idx;
    w_words_left_nxt = r_words_left;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (num_word == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_addr_nxt       = start_addr;
            w_words_left_nxt = num_word - LEN_WIDTH'(1);
            w_state_nxt      = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        w_shreg_nxt   = read_data;
        w_addr_nxt    = r_addr + ADDRESS_WIDTH'(1);
        w_bit_idx_nxt = '0;
        w_state_nxt   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_ready) begin
          if (r_bit_idx != LAST_IDX) begin
            w_shreg_nxt   = r_shreg >> 1;
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end else if (r_words_left != '0) begin
            // Next word is already on read_data: reload without a bubble.
            w_shreg_nxt      = read_data;
            w_addr_nxt       = r_addr + ADDRESS_WIDTH'(1);
            w_words_left_nxt = r_words_left - LEN_WIDTH'(1);
            w_bit_idx_nxt    = '0;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_done_nxt    = (w_state_nxt == ST_DONE);
    w_valid_nxt   = (w_state_nxt == ST_SHIFT);
    w_bit_out_nxt = w_valid_nxt & w_shreg_nxt[0];
    w_last_nxt    = w_valid_nxt && (w_words_left_nxt == '0) && (w_bit_idx_nxt == LAST_IDX);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_shreg      <= '0;
      r_bit_idx    <= '0;
      r_words_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_bit_out    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_words_left <= w_words_left_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_valid      <= w_valid_nxt;
      r_last       <= w_last_nxt;
      r_bit_out    <= w_bit_out_nxt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign read_address = r_addr;
  assign bit_valid    = r_valid;
  assign bit_last     = r_last;
  assign bit_out      = r_bit_out;

endmodule

// File: tb/tb_dpram_bit_reader.sv
// Directed bench for dpram_bit_reader with a behavioural same-cycle-read RAM.
module tb_dpram_bit_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] num_word;
  logic        busy;
  logic        done;
  logic [10:0] read_address;
  logic [7:0]  read_data;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_last;

  logic [7:0] ram [0:2047];
  assign read_data = ram[read_address];

  dpram_bit_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .num_word     (num_word),
    .busy         (busy),
    .done         (done),
    .read_address (read_address),
    .read_data    (read_data),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .bit_last     (bit_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit          q_bits[$];
  bit          q_last[$];
  logic [10:0] q_addr[$];
  int n_done, n_valid, n_busy, n_last, first_valid, last_hs, done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int k);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < q_bits.size()) b[j] = q_bits[8*k + j];
    return b;
  endfunction

  // Launch one packet and observe it until a few cycles past done.
  task automatic run_pkt(input logic [10:0] sa, input logic [11:0] nw,
                         input bit stall, input int restart_at);
    bit   pat [4];
    bit   prev_stall;
    logic prev_bit;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    q_bits.delete(); q_last.delete(); q_addr.delete();
    n_done = 0; n_valid = 0; n_busy = 0; n_last = 0;
    first_valid = -1; last_hs = -1; done_cyc = -1;
    start_addr = sa; num_word = nw; start = 1'b1;
    tick();
    start = 1'b0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      start = (i == restart_at);
      if (i == restart_at) start_addr = 11'd100;
      bit_ready = stall ? pat[i % 4] : 1'b1;
      if (busy) begin
        n_busy++;
        if (q_addr.size() == 0 || read_address != q_addr[$]) q_addr.push_back(read_address);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bit_valid), 32'd1);
        check("stall_hold", 32'(bit_out), 32'(prev_bit));
      end
      if (bit_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = i;
        if (bit_ready) begin
          q_bits.push_back(bit_out);
          q_last.push_back(bit_last);
          last_hs = i;
          if (bit_last) n_last++;
        end
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = i;
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      if (done_cyc >= 0 && i >= done_cyc + 3) break;
      tick();
    end
    start = 1'b0;
    bit_ready = 1'b0;
    if (done_cyc < 0) check("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    int n_done_rst;
    rst = 1'b0; start = 1'b0; start_addr = '0; num_word = '0; bit_ready = 1'b0;
    for (int a = 0; a < 2048; a++) ram[a] = 8'h00;
    ram[0] = 8'hA5; ram[1] = 8'h3C; ram[2] = 8'h01;
    ram[2046] = 8'h11; ram[2047] = 8'h22;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_last", 32'(bit_last), 32'd0);
    check("rst_bit", 32'(bit_out), 32'd0);
    check("rst_addr", 32'(read_address), 32'd0);
    rst = 1'b1;
    tick();

    // Basic 3-word packet, ready held high
    run_pkt(11'd0, 12'd3, 1'b0, -1);
    check("p1_nbits", q_bits.size(), 32'd24);
    check("p1_b0", 32'(byte_of(0)), 32'hA5);
    check("p1_b1", 32'(byte_of(1)), 32'h3C);
    check("p1_b2", 32'(byte_of(2)), 32'h01);
    check("p1_first_valid", 32'(first_valid), 32'd2);
    check("p1_nvalid", 32'(n_valid), 32'd24);
    check("p1_last_hs", 32'(last_hs), 32'd25);
    check("p1_done_cyc", 32'(done_cyc), 32'd26);
    check("p1_ndone", 32'(n_done), 32'd1);
    check("p1_nlast", 32'(n_last), 32'd1);
    check("p1_last_final", 32'(q_last[$]), 32'd1);
    check("p1_idle_busy", 32'(busy), 32'd0);

    // Same packet with ready pattern 1,0,0,1
    run_pkt(11'd0, 12'd3, 1'b1, -1);
    check("p2_nbits", q_bits.size(), 32'd24);
    check("p2_b0", 32'(byte_of(0)), 32'hA5);
    check("p2_b1", 32'(byte_of(1)), 32'h3C);
    check("p2_b2", 32'(byte_of(2)), 32'h01);
    check("p2_ndone", 32'(n_done), 32'd1);
    check("p2_nlast", 32'(n_last), 32'd1);
    check("p2_last_final", 32'(q_last[$]), 32'd1);

    // Address wrap at the top of the RAM
    ram[0] = 8'h33;
    run_pkt(11'd2046, 12'd3, 1'b0, -1);
    check("p3_addr0", 32'(q_addr[0]), 32'd2046);
    check("p3_addr1", 32'(q_addr[1]), 32'd2047);
    check("p3_addr2", 32'(q_addr[2]), 32'd0);
    check("p3_b0", 32'(byte_of(0)), 32'h11);
    check("p3_b1", 32'(byte_of(1)), 32'h22);
    check("p3_b2", 32'(byte_of(2)), 32'h33);
    check("p3_nbits", q_bits.size(), 32'd24);
    ram[0] = 8'hA5;

    // Zero-length packet
    run_pkt(11'd5, 12'd0, 1'b0, -1);
    check("p4_nvalid", 32'(n_valid), 32'd0);
    check("p4_nbusy", 32'(n_busy), 32'd1);
    check("p4_done_cyc", 32'(done_cyc), 32'd1);
    check("p4_ndone", 32'(n_done), 32'd1);

    // Second start mid-packet is ignored
    run_pkt(11'd0, 12'd2, 1'b0, 5);
    check("p5_nbits", q_bits.size(), 32'd16);
    check("p5_b0", 32'(byte_of(0)), 32'hA5);
    check("p5_b1", 32'(byte_of(1)), 32'h3C);
    check("p5_ndone", 32'(n_done), 32'd1);
    check("p5_done_cyc", 32'(done_cyc), 32'd18);

    // Async reset in the middle of SHIFT
    start_addr = 11'd1; num_word = 12'd2; start = 1'b1; bit_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("p6_pre_valid", 32'(bit_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("p6_rst_valid", 32'(bit_valid), 32'd0);
    check("p6_rst_busy", 32'(busy), 32'd0);
    check("p6_rst_addr", 32'(read_address), 32'd0);
    tick();
    rst = 1'b1;
    n_done_rst = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done_rst++;
      tick();
    end
    check("p6_no_done", 32'(n_done_rst), 32'd0);
    check("p6_idle", 32'(busy), 32'd0);
    run_pkt(11'd1, 12'd2, 1'b0, -1);
    check("p6_b0", 32'(byte_of(0)), 32'h3C);
    check("p6_b1", 32'(byte_of(1)), 32'h01);
    check("p6_nbits", q_bits.size(), 32'd16);
    check("p6_ndone", 32'(n_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
